// File: rtl/md_sched.sv
// Multiply/divide sequencer between EX decode and the shared mul/div units.
// Optional macro MD_DIVZERO_BYPASS_EN: divide-by-zero completes without the divider.
module md_sched #(
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        md_err
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          sgn_q, sgn_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   result_q, result_d;
  logic          md_err_q, md_err_d;
  logic          div_zero;

`ifdef MD_DIVZERO_BYPASS_EN
  assign div_zero = op_code[1] && (src_b == 32'd0);
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sgn_d     = sgn_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    md_err_d  = md_err_q;
    stallreq  = 1'b0;
    div_start = 1'b0;
    div_annul = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (op_valid && !flush) begin
          stallreq = 1'b1;
          sgn_d    = ~op_code[0];
          a_d      = src_a;
          b_d      = src_b;
          if (div_zero) begin
            result_d = {src_a, 32'hFFFF_FFFF};
            state_d  = DONE;
          end else begin
            state_d = op_code[1] ? DIV_WAIT : MUL_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          stallreq = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == MUL_LAST) begin
            result_d = mul_result;
            state_d  = DONE;
          end
        end
      end
      DIV_WAIT: begin
        // Flush beats a same-cycle div_ready; timeout annuls just like a flush.
        if (flush) begin
          div_annul = 1'b1;
          state_d   = IDLE;
        end else if (div_ready) begin
          stallreq = 1'b1;
          result_d = div_result;
          state_d  = DONE;
        end else if (cnt_q == DIV_LAST) begin
          stallreq  = 1'b1;
          div_annul = 1'b1;
          md_err_d  = 1'b1;
          state_d   = IDLE;
        end else begin
          stallreq  = 1'b1;
          div_start = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sgn_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sgn_q    <= sgn_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      md_err_q <= md_err_d;
    end
  end

  assign mul_signed = (state_q == MUL_WAIT) && sgn_q;
  assign mul_a      = (state_q == MUL_WAIT) ? a_q : 32'd0;
  assign mul_b      = (state_q == MUL_WAIT) ? b_q : 32'd0;
  assign div_signed = (state_q == DIV_WAIT) && sgn_q;
  assign div_a      = (state_q == DIV_WAIT) ? a_q : 32'd0;
  assign div_b      = (state_q == DIV_WAIT) ? b_q : 32'd0;
  assign hi_we      = (state_q == DONE);
  assign lo_we      = (state_q == DONE);
  assign hi_wdata   = (state_q == DONE) ? result_q[63:32] : 32'd0;
  assign lo_wdata   = (state_q == DONE) ? result_q[31:0] : 32'd0;
  assign md_err     = md_err_q;

endmodule
